decoder_n_seq: RTL

//  Parametrised registered SEL_W-to-2^SEL_W one-hot decoder, successor to the 2-to-4 decoder.

---
 rtl/decoder_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/decoder_n_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared mode codes and FSM state encoding for the sequenced one-hot decoder.
package decoder_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_LOAD    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SCAN_UP = 2'b10;
    localparam logic [MODE_W-1:0] MODE_SCAN_DN = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: counts 0..div and flags the cycle where count equals div.
module tick_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_cnt;

    // Clear wins over counting so a clear cycle never produces a tick.
    assign o_tick_c = i_run && !i_clr && (r_cnt == i_div);

    // Count register: restart after each tick, wrap naturally at DIV_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (o_tick_c) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with load and up/down scan modes.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned DIV_W      = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic [MODE_W-1:0]       i_mode,
    input  logic [SEL_W-1:0]        i_sel_in,
    input  logic                    i_load_vld,
    output logic                    o_load_rdy,
    input  logic [DIV_W-1:0]        i_div,
    output logic [(2**SEL_W)-1:0]   o_d_out,
    output logic [SEL_W-1:0]        o_idx_out,
    output logic                    o_wrap
);

    localparam int unsigned NOUT = 2**SEL_W;
    localparam logic [NOUT-1:0] INACTIVE = {NOUT{ACTIVE_LOW}};

    state_e            r_state;
    logic [MODE_W-1:0] r_mode;
    logic [SEL_W-1:0]  r_idx;
    logic [NOUT-1:0]   r_d_out;
    logic              r_wrap;

    logic              w_run;
    logic              w_scan;
    logic              w_mode_chg;
    logic              w_presc_clr;
    logic              w_tick;
    logic              w_load;
    logic [SEL_W-1:0]  w_idx_nxt;
    logic              w_wrap_nxt;
    logic [NOUT-1:0]   w_onehot;

    assign w_run       = (r_state == ST_RUN);
    assign w_scan      = (i_mode == MODE_SCAN_UP) || (i_mode == MODE_SCAN_DN);
    assign w_mode_chg  = (i_mode != r_mode);
    // Prescaler only runs while scanning in RUN with a stable mode.
    assign w_presc_clr = !w_run || !w_scan || w_mode_chg;
    assign o_load_rdy  = w_run && (i_mode == MODE_LOAD);
    assign w_load      = o_load_rdy && i_load_vld;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_presc_clr),
        .i_run    (w_scan),
        .i_div    (i_div),
        .o_tick_c (w_tick)
    );

    // Next index: load takes sel_in, a tick steps modulo NOUT and flags wrap.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        if (w_load) begin
            w_idx_nxt = i_sel_in;
        end else if (w_tick) begin
            if (i_mode == MODE_SCAN_UP) begin
                w_idx_nxt  = r_idx + SEL_W'(1);
                w_wrap_nxt = (r_idx == {SEL_W{1'b1}});
            end else begin
                w_idx_nxt  = r_idx - SEL_W'(1);
                w_wrap_nxt = (r_idx == {SEL_W{1'b0}});
            end
        end
    end

    assign w_onehot = NOUT'(1) << w_idx_nxt;

    // FSM with registered index, decoded output and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_HOLD;
            r_idx   <= '0;
            r_d_out <= INACTIVE;
            r_wrap  <= 1'b0;
        end else begin
            r_mode <= i_mode;
            r_idx  <= w_idx_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_wrap <= 1'b0;
                    if (i_en) begin
                        r_state <= ST_RUN;
                        r_d_out <= w_onehot ^ INACTIVE;
                    end else begin
                        r_d_out <= INACTIVE;
                    end
                end
                ST_RUN: begin
                    if (i_en) begin
                        r_d_out <= w_onehot ^ INACTIVE;
                        r_wrap  <= w_wrap_nxt;
                    end else begin
                        r_state <= ST_IDLE;
                        r_d_out <= INACTIVE;
                        r_wrap  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_d_out <= INACTIVE;
                    r_wrap  <= 1'b0;
                end
            endcase
        end
    end

    assign o_d_out   = r_d_out;
    assign o_idx_out = r_idx;
    assign o_wrap    = r_wrap;

endmodule
